// File: rtl/reg_bank_pkg.sv
// Shared types and constants for the capture register bank.
package reg_bank_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_e;

    localparam int unsigned CNT_MODE_WRAP = 0;
    localparam int unsigned CNT_MODE_SAT  = 1;

endpackage

// File: rtl/reg_bank_timer.sv
// Periodic timer: counts 0..timer_period and emits a registered one-cycle tick at the terminal.
module reg_bank_timer #(
    parameter int unsigned TIMER_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [TIMER_W-1:0] timer_period,
    output logic               timer_tick
);

    logic [TIMER_W-1:0] count_q, count_d;
    logic               tick_q, tick_d;
    logic               wrap;

    // >= rather than == so a period lowered below the current count wraps at once.
    always_comb begin
        wrap    = (count_q >= timer_period);
        count_d = wrap ? '0 : count_q + TIMER_W'(1);
        tick_d  = wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign timer_tick = tick_q;

endmodule

// File: rtl/capture_register_bank.sv
// Debug/statistics capture unit: sample and status registers, event counter, timer,
// and a triggered capture FSM streaming samples into a host-accessible memory.
module capture_register_bank
    import reg_bank_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned STATUS_W = 16,
    parameter int unsigned TIMER_W  = 12,
    parameter int unsigned CNT_SAT  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       data_valid,
    output logic [DATA_W-1:0]          data_out,
    input  logic                       cnt_en,
    output logic [CNT_W-1:0]           counter,
    output logic [STATUS_W-1:0]        status,
    input  logic [TIMER_W-1:0]         timer_period,
    output logic                       timer_tick,
    input  logic                       arm,
    input  logic                       abort,
    output logic [1:0]                 cap_state,
    output logic [$clog2(DEPTH):0]     cap_count,
    output logic                       mem_busy,
    input  logic                       mem_we,
    input  logic                       mem_re,
    input  logic [$clog2(DEPTH)-1:0]   mem_addr,
    input  logic [DATA_W-1:0]          mem_wdata,
    output logic [DATA_W-1:0]          mem_rdata,
    output logic                       mem_rvalid
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0]   data_q, data_d;
    logic [STATUS_W-1:0] status_q, status_d;
    logic [CNT_W-1:0]    counter_q, counter_d;
    cap_state_e          state_q, state_d;
    logic [CW-1:0]       cap_count_q, cap_count_d;
    logic                mem_busy_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                rvalid_q;

    logic                cap_we;
    logic [AW-1:0]       cap_addr;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    always_comb begin
        data_d   = data_q;
        status_d = status_q;
        if (data_valid) begin
            data_d   = data_in;
            status_d = {status_q[STATUS_W-2:0], data_in[0]};
        end
        counter_d = counter_q;
        if (cnt_en && !(CNT_SAT == CNT_MODE_SAT && (&counter_q))) begin
            counter_d = counter_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        cap_count_d = cap_count_q;
        cap_we      = 1'b0;
        cap_addr    = '0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (arm) begin
                        state_d     = ARMED;
                        cap_count_d = '0;
                    end
                end
                ARMED: begin
                    if (data_valid && data_in[DATA_W-1]) begin
                        state_d     = CAPTURE;
                        cap_we      = 1'b1;
                        cap_count_d = CW'(1);
                    end
                end
                CAPTURE: begin
                    if (data_valid) begin
                        cap_we      = 1'b1;
                        cap_addr    = cap_count_q[AW-1:0];
                        cap_count_d = cap_count_q + CW'(1);
                        if (cap_count_d == CW'(DEPTH)) begin
                            state_d = DONE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Single write port; the trigger write (not yet busy) still wins over a host write.
    always_comb begin
        wr_en   = cap_we | (mem_we & ~mem_busy_q);
        wr_addr = cap_we ? cap_addr : mem_addr;
        wr_data = cap_we ? data_in : mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q      <= '0;
            status_q    <= '0;
            counter_q   <= '0;
            state_q     <= IDLE;
            cap_count_q <= '0;
            mem_busy_q  <= 1'b0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            data_q      <= data_d;
            status_q    <= status_d;
            counter_q   <= counter_d;
            state_q     <= state_d;
            cap_count_q <= cap_count_d;
            mem_busy_q  <= (state_d == CAPTURE);
            rvalid_q    <= mem_re;
            if (mem_re) begin
                rdata_q <= mem_q[mem_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    reg_bank_timer #(
        .TIMER_W(TIMER_W)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .timer_period(timer_period),
        .timer_tick  (timer_tick)
    );

    assign data_out   = data_q;
    assign status     = status_q;
    assign counter    = counter_q;
    assign cap_state  = state_q;
    assign cap_count  = cap_count_q;
    assign mem_busy   = mem_busy_q;
    assign mem_rdata  = rdata_q;
    assign mem_rvalid = rvalid_q;

endmodule
